if_fetch: RTL

//  Instruction-fetch stage feeding the IF/ID pipeline register. Holds the fetch PC, drives a req/ready

---
 rtl/if_fetch_pkg.sv | 13 +
 rtl/if_fetch_if.sv | 10 +
 rtl/if_fetch_perf_cnt.sv | 25 ++
 rtl/if_fetch.sv | 130 +++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared fetch-stage state encoding and default constants
package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction-memory req/ready port between fetch stage and memory
interface if_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_perf_cnt.sv
// rtl/if_fetch_perf_cnt.sv - free-running wrapping event counters for the fetch stage
module if_fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_fetch,
    input  logic        inc_wait,
    input  logic        inc_drop,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_wait,
    output logic [31:0] perf_drop
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_wait  <= '0;
            perf_drop  <= '0;
        end else begin
            perf_fetch <= perf_fetch + {31'd0, inc_fetch};
            perf_wait  <= perf_wait  + {31'd0, inc_wait};
            perf_drop  <= perf_drop  + {31'd0, inc_drop};
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with one-entry slot; IF_PERF_CNT_EN adds perf counters
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_wr,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    if_fetch_if.master         imem,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        inst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_wait,
    output logic [31:0]        perf_drop,
`endif
    output logic               fetch_valid
);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  pend_pc, pend_pc_n;
    logic [31:0]  slot_pc, slot_pc_n;
    logic [31:0]  slot_inst, slot_inst_n;
    logic         valid_n;
    logic         req, accept, consume, redirect;
    logic [31:0]  tgt;

    always_comb begin
        redirect    = br_taken | jump;
        tgt         = br_taken ? br_target : jump_target;
        consume     = fetch_valid & pc_wr;
        req         = 1'b0;
        accept      = 1'b0;
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        pend_pc_n   = pend_pc;
        slot_pc_n   = slot_pc;
        slot_inst_n = slot_inst;
        valid_n     = fetch_valid;

        case (state)
            ST_IDLE: begin
                state_n = ST_FETCH;
                if (redirect) fetch_pc_n = tgt;
            end
            ST_FETCH: begin
                // A raised request always leaves the slot empty, so req stays up until ready.
                req    = !fetch_valid | consume;
                accept = req & imem.ready & !redirect;
                if (redirect) begin
                    valid_n = 1'b0;
                    if (req && !imem.ready) begin
                        pend_pc_n = tgt;
                        state_n   = ST_DRAIN;
                    end else begin
                        fetch_pc_n = tgt;
                    end
                end else if (accept) begin
                    slot_pc_n   = fetch_pc;
                    slot_inst_n = imem.rdata;
                    valid_n     = 1'b1;
                    fetch_pc_n  = fetch_pc + 32'd4;
                end else if (consume) begin
                    valid_n = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Stale request must complete at its original address; its data is discarded.
                req     = 1'b1;
                valid_n = 1'b0;
                if (redirect) pend_pc_n = tgt;
                if (imem.ready) begin
                    fetch_pc_n = redirect ? tgt : pend_pc;
                    state_n    = ST_FETCH;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            pend_pc     <= RESET_PC;
            slot_pc     <= '0;
            slot_inst   <= NOP_INST;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            pend_pc     <= pend_pc_n;
            slot_pc     <= slot_pc_n;
            slot_inst   <= slot_inst_n;
            fetch_valid <= valid_n;
        end
    end

    assign imem.req  = req;
    assign imem.addr = fetch_pc;
    assign pc        = slot_pc;
    assign pc_plus4  = slot_pc + 32'd4;
    assign inst      = fetch_valid ? slot_inst : NOP_INST;

`ifdef IF_PERF_CNT_EN
    logic inc_wait, inc_drop;
    assign inc_wait = req & !imem.ready;
    assign inc_drop = req & imem.ready & ((state == ST_DRAIN) | redirect);

    if_fetch_perf_cnt u_perf (
        .clk        (clk),
        .rst        (rst),
        .inc_fetch  (accept),
        .inc_wait   (inc_wait),
        .inc_drop   (inc_drop),
        .perf_fetch (perf_fetch),
        .perf_wait  (perf_wait),
        .perf_drop  (perf_drop)
    );
`endif

endmodule
